nn_activation_pipe: RTL and testbench
=====================================

// Module: nn_activation_pipe
// PURPOSE
//  Multi-lane, mode-selectable activation unit for the speech-recognition NN datapath.
//  - Applies pass-through, ReLU, leaky ReLU or clipped ReLU to LANES signed fixed-point values per beat.
//  - Sits between the MAC/accumulator output and the next layer's input buffer.
//  - Uses a 2-stage valid/ready pipeline with frame framing and a per-frame zero-clamp statistic.
// PARAMETERS
//  DATA_W      16  width of each signed lane value
//  LANES       4   lanes processed per beat
//  LEAK_SHIFT  3   leaky slope = 2^-LEAK_SHIFT (arithmetic right shift)
//  CNT_W       16  width of the saturating per-frame zero counter
// PORTS
//  clk         in   1               single clock, all logic on rising edge
//  rst_n       in   1               synchronous, active-low reset
//  mode        in   2               00 pass, 01 ReLU, 10 leaky ReLU, 11 clipped ReLU
//  clip_val    in   DATA_W          signed clip ceiling for mode 11
//  in_valid    in   1               input beat valid
//  in_ready    out  1               block can accept a beat
//  in_data     in   LANES*DATA_W    packed signed lanes; lane0 = LSBs
//  in_last     in   1               last beat of the frame
//  out_valid   out  1               output beat valid
//  out_ready   in   1               downstream accepts the beat
//  out_data    out  LANES*DATA_W    activated lanes, same packing
//  out_last    out  1               in_last delayed to match out_data
//  zero_count  out  CNT_W           count of clamped lanes in the frame; valid on the out_last beat
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): s1/s2 valid=0; out_valid=0; out_data=0; out_last=0; zero_count=0.
//   - The frame-config register reloads on the next accepted beat. The frame-start flag is set to 1.
//   - Reset asserted mid-frame drops all in-flight beats; no partial output is produced.
//  Handshake: a beat transfers when valid&ready. Data is held stable while out_valid&!out_ready.
//   - s2_ready = !s2_valid | out_ready; s1_ready = !s1_valid | s2_ready; in_ready = s1_ready.
//   - The combinational out_ready->in_ready path is permitted.
//  Latency: 2 cycles from input accept to out_valid when there is no backpressure.
//   - Throughput is 1 beat/cycle. No bubbles are inserted. No beat is lost or reordered.
//  Frame config: mode and clip_val are latched on the first accepted beat of a frame.
//   - The first beat is the first beat after reset or after an accepted in_last.
//   - Changes to mode or clip_val mid-frame are ignored until the next frame.
//  Stage 1: registers the input and the latched config, and computes the per-lane activation:
//   - pass: y=x.
//   - ReLU: y = x<0 ? 0 : x.
//   - leaky: y = x<0 ? x>>>LEAK_SHIFT : x. Floor rounding, so -1 gives -1.
//   - clip: y = x<0 ? 0 : (x>c ? c : x), where c = max(clip_val,0).
//   - All results stay in DATA_W. No widening and no overflow is possible.
//  A lane counts as clamped when mode is ReLU or clip and x<0.
//   - Clip saturation at the top does not count. Stage 1 produces the per-beat clamp count, 0..LANES.
//  Stage 2: registers out_data and out_last, and accumulates the frame counter.
//   - Update rule: acc = (first beat of frame ? 0 : acc) + beat_count.
//   - acc saturates at 2^CNT_W-1.
//   - zero_count shows acc including the current beat and holds until the next s2 load.
//   - It is meaningful only when out_valid&out_last.
//  Single-beat frame (in_last on the first beat): the counter equals that beat's count only.
//  Simultaneous accept on input and output in the same cycle is normal streaming; both transfers occur.
// STRUCTURE
//  Package nn_act_pkg holds:
//   - MODE_PASS=2'b00, MODE_RELU=2'b01, MODE_LEAKY=2'b10, MODE_CLIP=2'b11.
//   - The default DATA_W/LANES constants.
//  Sub-module nn_act_lane is the purely combinational single-lane activation.
//   - Inputs: x, mode, clip_val. Outputs: y, clamped.
//   - It is instantiated LANES times by generate inside stage 1.
//  Top level contains the 2-stage pipeline, the frame-start/config registers and the saturating counter.
// TESTING (DATA_W=16, LANES=4, LEAK_SHIFT=3)
//  T1 Reset: hold rst_n=0 for 2 clk -> out_valid=0, out_data=0, zero_count=0; in_ready=1 after release.
//  T2 ReLU: mode=01, lanes {32767,-32768,1234,-1234}, in_last=1
//     -> 2 clk later out {32767,0,1234,0}, out_last=1, zero_count=2.
//  T3 Leaky/clip:
//     - mode=10, lanes {-8,-1,-32768,100} -> {-1,-1,-4096,100}.
//     - mode=11, clip_val=1536, lanes {2000,-5,1536,1535} -> {1536,0,1536,1535}.
//  T4 Backpressure: send 6 beats with out_ready=0 for 5 cycles
//     -> in_ready drops after 2 accepts; all 6 beats emerge in order with no loss or duplication.
//  T5 Mid-frame mode change: 3-beat frame started in ReLU, switch mode to 00 after beat 1
//     -> all 3 beats are ReLU; the next frame is pass-through.
//     -> zero_count covers that frame only.
//  T6 Reset mid-frame: assert rst_n=0 while 2 beats are in flight
//     -> out_valid=0 the next cycle; the following frame's zero_count excludes the dropped beats.

Source files
------------

// File: rtl/nn_act_pkg.sv
// Shared constants for the activation pipeline.
// Mode encodings and default datapath geometry.
package nn_act_pkg;
  localparam logic [1:0] MODE_PASS  = 2'b00;
  localparam logic [1:0] MODE_RELU  = 2'b01;
  localparam logic [1:0] MODE_LEAKY = 2'b10;
  localparam logic [1:0] MODE_CLIP  = 2'b11;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_LANES  = 4;
endpackage

// File: rtl/nn_activation_pipe_lane.sv
// Single-lane combinational activation.
// Reports whether a negative input was forced to zero.
module nn_act_lane
  import nn_act_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LEAK_SHIFT = 3
) (
  input  logic signed [DATA_W-1:0] x,
  input  logic        [1:0]        mode,
  input  logic signed [DATA_W-1:0] clip_val,
  output logic signed [DATA_W-1:0] y,
  output logic                     clamped
);

  logic signed [DATA_W-1:0] c;
  logic                     neg;

  always_comb begin
    c       = clip_val[DATA_W-1] ? '0 : clip_val;
    neg     = x[DATA_W-1];
    y       = x;
    clamped = 1'b0;
    unique case (mode)
      MODE_RELU: begin
        if (neg) begin
          y       = '0;
          clamped = 1'b1;
        end
      end
      MODE_LEAKY: begin
        if (neg) y = x >>> LEAK_SHIFT;
      end
      MODE_CLIP: begin
        if (neg) begin
          y       = '0;
          clamped = 1'b1;
        end else if (x > c) begin
          y = c;
        end
      end
      default: y = x;
    endcase
  end

endmodule

// File: rtl/nn_activation_pipe.sv
// Two-stage valid/ready activation pipe with per-frame
// config latch and saturating zero-clamp counter.
module nn_activation_pipe
  import nn_act_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LANES      = DEF_LANES,
  parameter int LEAK_SHIFT = 3,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              mode,
  input  logic [DATA_W-1:0]       clip_val,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    out_last,
  output logic [CNT_W-1:0]        zero_count
);

  localparam int CW = $clog2(LANES + 1);

  logic                    first_q, first_d;
  logic [1:0]              cfg_mode_q, cfg_mode_d;
  logic [DATA_W-1:0]       cfg_clip_q, cfg_clip_d;

  logic                    s1_valid_q, s1_valid_d;
  logic [LANES*DATA_W-1:0] s1_data_q, s1_data_d;
  logic [1:0]              s1_mode_q, s1_mode_d;
  logic [DATA_W-1:0]       s1_clip_q, s1_clip_d;
  logic                    s1_first_q, s1_first_d;
  logic                    s1_last_q, s1_last_d;

  logic                    s2_valid_q, s2_valid_d;
  logic [LANES*DATA_W-1:0] s2_data_q, s2_data_d;
  logic                    s2_last_q, s2_last_d;
  logic [CNT_W-1:0]        acc_q, acc_d;

  logic                    s1_ready, s2_ready;
  logic [LANES*DATA_W-1:0] act_data;
  logic [LANES-1:0]        lane_clamp;
  logic [CW-1:0]           beat_cnt;
  logic [CNT_W-1:0]        acc_base;
  logic [CNT_W:0]          acc_sum;

  assign s2_ready = !s2_valid_q || out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign in_ready = s1_ready;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    nn_act_lane #(
      .DATA_W    (DATA_W),
      .LEAK_SHIFT(LEAK_SHIFT)
    ) u_lane (
      .x       (s1_data_q[g*DATA_W +: DATA_W]),
      .mode    (s1_mode_q),
      .clip_val(s1_clip_q),
      .y       (act_data[g*DATA_W +: DATA_W]),
      .clamped (lane_clamp[g])
    );
  end

  always_comb begin
    beat_cnt = '0;
    for (int i = 0; i < LANES; i++)
      beat_cnt = beat_cnt + CW'(lane_clamp[i]);
    acc_base = s1_first_q ? '0 : acc_q;
    acc_sum  = {1'b0, acc_base} + (CNT_W+1)'(beat_cnt);
  end

  always_comb begin
    first_d    = first_q;
    cfg_mode_d = cfg_mode_q;
    cfg_clip_d = cfg_clip_q;
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    s1_clip_d  = s1_clip_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_last_d  = s2_last_q;
    acc_d      = acc_q;

    if (s1_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        // first beat of a frame uses live config and latches it
        s1_data_d  = in_data;
        s1_mode_d  = first_q ? mode : cfg_mode_q;
        s1_clip_d  = first_q ? clip_val : cfg_clip_q;
        s1_first_d = first_q;
        s1_last_d  = in_last;
        first_d    = in_last;
        if (first_q) begin
          cfg_mode_d = mode;
          cfg_clip_d = clip_val;
        end
      end
    end

    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = act_data;
        s2_last_d = s1_last_q;
        acc_d     = acc_sum[CNT_W] ? '1 : acc_sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_q    <= 1'b1;
      cfg_mode_q <= MODE_PASS;
      cfg_clip_q <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= MODE_PASS;
      s1_clip_q  <= '0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_last_q  <= 1'b0;
      acc_q      <= '0;
    end else begin
      first_q    <= first_d;
      cfg_mode_q <= cfg_mode_d;
      cfg_clip_q <= cfg_clip_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_mode_q  <= s1_mode_d;
      s1_clip_q  <= s1_clip_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_last_q  <= s2_last_d;
      acc_q      <= acc_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_data   = s2_data_q;
  assign out_last   = s2_last_q;
  assign zero_count = acc_q;

endmodule

// File: tb/tb_nn_activation_pipe.sv
// Testbench for nn_activation_pipe: directed table,
// corner sequences and random traffic vs a frame-level model.
module tb_nn_activation_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic [15:0] clip_val;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;
  logic [15:0] zero_count;

  always #5 clk = ~clk;

  nn_activation_pipe #(
    .DATA_W(16), .LANES(4), .LEAK_SHIFT(3), .CNT_W(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .clip_val  (clip_val),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .zero_count(zero_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input longint a, input longint e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic logic [63:0] pack4(input int a, input int b,
                                        input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  // floor(x / 2^3) written as integer division, not a shift
  function automatic int act(input int x, input int m, input int clip);
    int c;
    c = (clip < 0) ? 0 : clip;
    case (m)
      1: return (x < 0) ? 0 : x;
      2: return (x < 0) ? -((-x + 7) / 8) : x;
      3: return (x < 0) ? 0 : ((x > c) ? c : x);
      default: return x;
    endcase
  endfunction

  typedef struct {
    logic [63:0] data;
    bit          last;
    int          zc;
  } exp_t;

  exp_t sbq[$];
  bit   m_first = 1'b1;
  int   m_mode, m_clip, m_acc;
  int   acc_cnt = 0;
  int   pop_cnt = 0;

  // reference model + scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    exp_t e, g;
    int   x, cnt;
    if (!rst_n) begin
      sbq.delete();
      m_first = 1'b1;
    end else begin
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (sbq.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL sb_unexpected: got beat %0h expected none", out_data);
        end else begin
          g = sbq.pop_front();
          chk("sb_data", out_data, g.data);
          chk("sb_last", out_last, g.last);
          if (g.last) chk("sb_zero_count", zero_count, g.zc);
        end
      end
      if (in_valid && in_ready) begin
        acc_cnt++;
        if (m_first) begin
          m_mode = mode;
          m_clip = $signed(clip_val);
          m_acc  = 0;
        end
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
          x = $signed(in_data[i*16 +: 16]);
          e.data[i*16 +: 16] = 16'(act(x, m_mode, m_clip));
          if ((m_mode == 1 || m_mode == 3) && x < 0) cnt++;
        end
        m_acc = m_acc + cnt;
        if (m_acc > 65535) m_acc = 65535;
        e.last = in_last;
        e.zc   = m_acc;
        sbq.push_back(e);
        m_first = in_last;
      end
    end
  end

  task automatic send(input logic [1:0] m, input logic [15:0] c,
                      input logic [63:0] d, input logic l);
    bit took;
    mode     = m;
    clip_val = c;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      if (took) break;
      if (k == 199) chk("send_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      if (sbq.size() == 0) break;
      @(posedge clk);
    end
    #1;
    chk("drain_empty", sbq.size(), 0);
  endtask

  typedef struct {
    logic [1:0]  m;
    logic [15:0] c;
    logic [63:0] din;
    logic [63:0] dout;
    int          zc;
  } vec_t;

  vec_t tbl[4];
  bit   rdone;

  initial begin
    rst_n     = 1'b0;
    mode      = 2'b00;
    clip_val  = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    tbl[0] = '{2'b01, 16'd0, pack4(32767, -32768, 1234, -1234),
               pack4(32767, 0, 1234, 0), 2};
    tbl[1] = '{2'b10, 16'd0, pack4(-8, -1, -32768, 100),
               pack4(-1, -1, -4096, 100), 0};
    tbl[2] = '{2'b11, 16'd1536, pack4(2000, -5, 1536, 1535),
               pack4(1536, 0, 1536, 1535), 1};
    tbl[3] = '{2'b00, 16'd0, pack4(-7, 5, -32768, 0),
               pack4(-7, 5, -32768, 0), 0};

    // T1 reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_zero_count", zero_count, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // T2/T3 single-beat frames from the table
    foreach (tbl[v]) begin
      int  lat;
      bit  got;
      lat = 0;
      got = 0;
      send(tbl[v].m, tbl[v].c, tbl[v].din, 1'b1);
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (out_valid) begin
          lat = k;
          got = 1;
          break;
        end
      end
      chk("tbl_got_output", got, 1);
      chk("tbl_latency", lat, 2);
      chk("tbl_data", out_data, tbl[v].dout);
      chk("tbl_last", out_last, 1);
      chk("tbl_zero_count", zero_count, tbl[v].zc);
      @(posedge clk);
      #1;
    end
    drain();

    // T4 backpressure: 6 beats, output stalled for 5 cycles
    out_ready = 1'b0;
    acc_cnt   = 0;
    pop_cnt   = 0;
    fork
      begin
        for (int b = 0; b < 6; b++)
          send(2'b01, 16'd0, pack4(b, -b - 1, 100 * b, -3), b == 5);
      end
      begin
        repeat (5) @(posedge clk);
        #2;
        chk("bp_accepts", acc_cnt, 2);
        chk("bp_in_ready", in_ready, 0);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_pop_count", pop_cnt, 6);

    // T5 mode change mid-frame, then a pass-through frame
    send(2'b01, 16'd0, pack4(-1, 2, -3, 4), 1'b0);
    send(2'b00, 16'd0, pack4(-5, -6, 7, 8), 1'b0);
    send(2'b00, 16'd0, pack4(9, -10, -11, -12), 1'b1);
    send(2'b00, 16'd0, pack4(-20, -21, 22, 23), 1'b1);
    drain();

    // T6 reset with two beats in flight
    out_ready = 1'b0;
    send(2'b01, 16'd0, pack4(-1, -2, -3, -4), 1'b0);
    send(2'b01, 16'd0, pack4(-1, -2, -3, -4), 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_zero_count", zero_count, 0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(2'b01, 16'd0, pack4(-9, 3, 4, 5), 1'b1);
    drain();

    // random traffic with random backpressure
    pop_cnt = 0;
    acc_cnt = 0;
    rdone   = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          logic [63:0] d;
          d = {$urandom, $urandom};
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          send(2'($urandom_range(0, 3)),
               16'($urandom_range(0, 4000) - 1000),
               d, $urandom_range(0, 3) == 0);
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #1 out_ready = $urandom_range(0, 3) != 0;
        end
      end
    join
    out_ready = 1'b1;
    drain();
    chk("rand_beat_count", pop_cnt, acc_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
